// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Rates are expressed as half-periods of the 100 MHz system clock.
package clk_div_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  // Half-period in system clock cycles for a target output frequency.
  function automatic int unsigned half_div(input int unsigned hz);
    return CLK_HZ / (2 * hz);
  endfunction

  localparam int unsigned DIV_1HZ    = half_div(1);     // 50_000_000
  localparam int unsigned DIV_9600HZ = half_div(9600);  // 5208

  typedef enum logic [1:0] {
    ChSync,
    ChFrozen,
    ChHalted,
    ChRun
  } ch_mode_e;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: a half-period counter with active/pending divisor registers,
// producing a 50% duty square wave and a one-cycle tick on every rising edge.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W        = 27,
  parameter int unsigned DEF_HALF_DIV = DIV_9600HZ
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_half_div_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             div_pending_o
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_HALF_DIV);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             div_pend_q, div_pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  // Set at a phase point: the first terminal count after it keeps the output low,
  // so the first rise lands a full period (2*div) after reset, sync or restart.
  logic             skip_q, skip_d;
  ch_mode_e         mode;

  always_comb begin
    if (sync_i) begin
      mode = ChSync;
    end else if (!en_i) begin
      mode = ChFrozen;
    end else if (active_q == '0) begin
      mode = ChHalted;
    end else begin
      mode = ChRun;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    active_d   = active_q;
    pending_d  = pending_q;
    div_pend_d = div_pend_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    skip_d     = skip_q;

    if (wr_en_i) begin
      pending_d  = wr_half_div_i;
      div_pend_d = 1'b1;
    end

    unique case (mode)
      ChSync: begin
        cnt_d      = '0;
        clk_d      = 1'b0;
        skip_d     = 1'b1;
        div_pend_d = 1'b0;
        if (wr_en_i) begin
          active_d = wr_half_div_i;
        end else if (div_pend_q) begin
          active_d = pending_q;
        end
      end
      ChFrozen: ;
      ChHalted: begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        skip_d = 1'b1;
        if (div_pend_q) begin
          active_d   = pending_q;
          div_pend_d = wr_en_i;
        end
      end
      ChRun: begin
        if (cnt_q == active_q - One) begin
          cnt_d = '0;
          // A write landing on the boundary bypasses the pending register.
          if (wr_en_i) begin
            active_d   = wr_half_div_i;
            div_pend_d = 1'b0;
          end else if (div_pend_q) begin
            active_d   = pending_q;
            div_pend_d = 1'b0;
          end
          if (active_d == '0) begin
            clk_d  = 1'b0;
            skip_d = 1'b1;
          end else if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
          end
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      active_q   <= DefDiv;
      pending_q  <= DefDiv;
      div_pend_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      skip_q     <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      div_pend_q <= div_pend_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      skip_q     <= skip_d;
    end
  end

  assign clk_out_o     = clk_q;
  assign tick_o        = tick_q;
  assign div_pending_o = div_pend_q;

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable N-channel clock divider: per-channel square wave, rising-edge
// tick and divisor write port with boundary-aligned, glitch-free updates.
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned CNT_W        = 27,
  parameter int unsigned CH_W         = 4,
  parameter int unsigned DEF_HALF_DIV = DIV_9600HZ
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_half_div,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  div_pending
);

  logic [N_CH-1:0] ch_wr;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] ChIdx = CH_W'(i);

    // Indices at or above N_CH never match, so such writes are dropped.
    assign ch_wr[i] = wr_en && (wr_ch == ChIdx);

    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEF_HALF_DIV (DEF_HALF_DIV)
    ) u_ch (
      .clk_i         (clk_in),
      .rst_i         (rst),
      .en_i          (en),
      .sync_i        (sync),
      .wr_en_i       (ch_wr[i]),
      .wr_half_div_i (wr_half_div),
      .clk_out_o     (clk_out[i]),
      .tick_o        (tick[i]),
      .div_pending_o (div_pending[i])
    );
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog with N_CH=2, DEF_HALF_DIV=3: a vector table for
// reset/boundary-update behaviour plus hand sequences for halt, collision, en, sync, reset.
module tb_clk_divider_prog;

  localparam int unsigned N_CH  = 2;
  localparam int unsigned CNT_W = 27;
  localparam int unsigned CH_W  = 2;
  localparam int unsigned DEF   = 3;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             en;
  logic             sync;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_half_div;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  div_pending;

  int n_checks = 0;
  int n_pass   = 0;

  clk_divider_prog #(
    .N_CH         (N_CH),
    .CNT_W        (CNT_W),
    .CH_W         (CH_W),
    .DEF_HALF_DIV (DEF)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .sync        (sync),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_half_div (wr_half_div),
    .clk_out     (clk_out),
    .tick        (tick),
    .div_pending (div_pending)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_val;
    logic [1:0]       exp_clk;
    logic [1:0]       exp_tick;
    logic [1:0]       exp_pend;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t iv(input logic [1:0] c, input logic [1:0] t, input logic [1:0] p);
    vec_t v;
    v.wr_en    = 1'b0;
    v.wr_ch    = '0;
    v.wr_val   = '0;
    v.exp_clk  = c;
    v.exp_tick = t;
    v.exp_pend = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b, want %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic s, input logic w,
                      input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] val);
    en          = e;
    sync        = s;
    wr_en       = w;
    wr_ch       = ch;
    wr_half_div = val;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    // Both channels at half-div 3; ch1 gets 5 written mid half-period at edge 13.
    vecs[0]  = iv(2'b00, 2'b00, 2'b00);
    vecs[1]  = iv(2'b00, 2'b00, 2'b00);
    vecs[2]  = iv(2'b00, 2'b00, 2'b00);
    vecs[3]  = iv(2'b00, 2'b00, 2'b00);
    vecs[4]  = iv(2'b00, 2'b00, 2'b00);
    vecs[5]  = iv(2'b11, 2'b11, 2'b00);
    vecs[6]  = iv(2'b11, 2'b00, 2'b00);
    vecs[7]  = iv(2'b11, 2'b00, 2'b00);
    vecs[8]  = iv(2'b00, 2'b00, 2'b00);
    vecs[9]  = iv(2'b00, 2'b00, 2'b00);
    vecs[10] = iv(2'b00, 2'b00, 2'b00);
    vecs[11] = iv(2'b11, 2'b11, 2'b00);
    vecs[12] = iv(2'b11, 2'b00, 2'b10);
    vecs[12].wr_en  = 1'b1;
    vecs[12].wr_ch  = 2'd1;
    vecs[12].wr_val = 27'd5;
    vecs[13] = iv(2'b11, 2'b00, 2'b10);
    vecs[14] = iv(2'b00, 2'b00, 2'b00);
    vecs[15] = iv(2'b00, 2'b00, 2'b00);
    vecs[16] = iv(2'b00, 2'b00, 2'b00);
    vecs[17] = iv(2'b01, 2'b01, 2'b00);
    vecs[18] = iv(2'b01, 2'b00, 2'b00);
    vecs[19] = iv(2'b11, 2'b10, 2'b00);
    vecs[20] = iv(2'b10, 2'b00, 2'b00);
    vecs[21] = iv(2'b10, 2'b00, 2'b00);
    vecs[22] = iv(2'b10, 2'b00, 2'b00);
    vecs[23] = iv(2'b11, 2'b01, 2'b00);
    vecs[24] = iv(2'b01, 2'b00, 2'b00);

    rst = 1'b1; en = 1'b1; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_half_div = '0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_state", {2'b00, clk_out, tick, div_pending}, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(1'b1, 1'b0, vecs[i].wr_en, vecs[i].wr_ch, vecs[i].wr_val);
      chk($sformatf("vec%0d", i + 1), {2'b00, clk_out, tick, div_pending},
          {2'b00, vecs[i].exp_clk, vecs[i].exp_tick, vecs[i].exp_pend});
    end

    // Sync with ch0=2, then write ch0=4 exactly on its terminal count.
    step(1'b1, 1'b1, 1'b1, 2'd0, 27'd2);
    chk("sync_a", {2'b00, clk_out, tick, div_pending}, 8'h00);
    idle();
    idle();
    idle();
    chk("pre_collide", {7'd0, clk_out[0]}, 8'd0);
    step(1'b1, 1'b0, 1'b1, 2'd0, 27'd4);
    chk("collide_rise", {5'd0, clk_out[0], tick[0], div_pending[0]}, 8'b110);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("collide_high%0d", i), {6'd0, clk_out[0], div_pending[0]}, 8'b10);
    end
    idle();
    chk("collide_fall", {6'd0, clk_out[0], div_pending[0]}, 8'b00);

    // Halt ch0: pending until the next boundary, then held low with no ticks.
    step(1'b1, 1'b0, 1'b1, 2'd0, 27'd0);
    chk("halt_pend0", {7'd0, div_pending[0]}, 8'd1);
    idle();
    idle();
    chk("halt_pend2", {7'd0, div_pending[0]}, 8'd1);
    idle();
    chk("halt_apply", {6'd0, clk_out[0], div_pending[0]}, 8'b00);
    for (int i = 0; i < 8; i++) begin
      idle();
      chk($sformatf("halted%0d", i), {6'd0, clk_out[0], tick[0]}, 8'b00);
    end
    chk("ch1_indep", {6'd0, clk_out[1], tick[1]}, 8'b11);

    // Restart ch0 with 2: pending clears next cycle, first rise 4 cycles later.
    step(1'b1, 1'b0, 1'b1, 2'd0, 27'd2);
    chk("restart_pend", {7'd0, div_pending[0]}, 8'd1);
    idle();
    chk("restart_apply", {7'd0, div_pending[0]}, 8'd0);
    idle();
    idle();
    idle();
    chk("restart_low", {7'd0, clk_out[0]}, 8'd0);
    idle();
    chk("restart_rise", {6'd0, clk_out[0], tick[0]}, 8'b11);

    // Freeze for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0);
      chk($sformatf("frozen%0d", i), {4'd0, clk_out, tick}, 8'b0100);
    end

    // Write ch1=7, then sync together with ch0=3.
    step(1'b1, 1'b0, 1'b1, 2'd1, 27'd7);
    step(1'b1, 1'b1, 1'b1, 2'd0, 27'd3);
    chk("sync_b", {2'b00, clk_out, tick, div_pending}, 8'h00);
    for (int i = 1; i <= 14; i++) begin
      logic c0, c1, t0, t1;
      idle();
      c0 = (i >= 6 && i <= 8) || (i >= 12);
      c1 = (i >= 14);
      t0 = (i == 6) || (i == 12);
      t1 = (i == 14);
      chk($sformatf("sync_b%0d", i), {4'd0, clk_out, tick}, {4'd0, c1, c0, t1, t0});
    end

    // Write to a channel index that does not exist.
    step(1'b1, 1'b0, 1'b1, 2'd3, 27'd1);
    chk("invalid_wr", {4'd0, clk_out, div_pending}, 8'b1000);
    idle();
    idle();
    idle();
    chk("invalid_after", {4'd0, clk_out, tick}, 8'b1101);

    // Asynchronous reset mid-count; ch1 must come back with the default divisor.
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_now", {2'b00, clk_out, tick, div_pending}, 8'h00);
    #2;
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      idle();
      if (i == 5) chk("midrst_low", {4'd0, clk_out, tick}, 8'h00);
      if (i == 6) chk("midrst_rise", {4'd0, clk_out, tick}, 8'b1111);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
